// File: rtl/env_pkg.sv
// Shared envelope types and constants.
// Phase encoding plus default widths and the rate that holds the level.
package env_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

  localparam int ENV_WIDTH     = 24;
  localparam int ENV_VEL_WIDTH = 7;

  localparam logic [ENV_WIDTH-1:0] ENV_PEAK  = '1;
  localparam logic [ENV_WIDTH-1:0] RATE_HOLD = '0;

endpackage

// File: rtl/envelope_adsr_scaler.sv
// Registered unsigned multiply keeping the top WIDTH bits of the product.
// One cycle of latency; valid follows the enable by that cycle.
module env_scaler
  import env_pkg::*;
#(
  parameter int WIDTH = ENV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p,
  output logic             valid
);

  logic [WIDTH-1:0] prod_hi;
  logic [WIDTH-1:0] prod_unused;

  assign {prod_hi, prod_unused} =
    {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      p     <= '0;
      valid <= 1'b0;
    end else begin
      valid <= en;
      if (en) p <= prod_hi;
    end
  end

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator scaling an oscillator sample per tick.
// ENVELOPE_VELOCITY_EN adds a velocity port that sets the attack peak.
module envelope_adsr
  import env_pkg::*;
#(
  parameter int WIDTH     = ENV_WIDTH,
  parameter int VEL_WIDTH = ENV_VEL_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_tick,
  input  logic             gate,
  input  logic [WIDTH-1:0] sample_in,
  input  logic [WIDTH-1:0] attack_rate,
  input  logic [WIDTH-1:0] decay_rate,
  input  logic [WIDTH-1:0] release_rate,
  input  logic [WIDTH-1:0] sustain_level,
`ifdef ENVELOPE_VELOCITY_EN
  input  logic [VEL_WIDTH-1:0] velocity,
`endif
  output logic [WIDTH-1:0] sample_out,
  output logic             sample_valid,
  output logic             active,
  output env_state_t       env_state
);

  env_state_t state;

  logic                 gate_q;
  logic                 rise;
  logic                 fall;
  logic [WIDTH-1:0]     level;
  logic [WIDTH-1:0]     peak;
  logic [WIDTH-1:0]     target;
  logic [VEL_WIDTH-1:0] vel_q;
  logic [WIDTH:0]       atk_sum;
  logic signed [WIDTH:0] dec_diff;
  logic signed [WIDTH:0] rel_diff;

  assign rise = gate & ~gate_q;
  assign fall = ~gate & gate_q;

`ifdef ENVELOPE_VELOCITY_EN
  always_ff @(posedge clk) begin
    if (rst)       vel_q <= '1;
    else if (rise) vel_q <= velocity;
  end
`else
  assign vel_q = '1;
`endif

  assign peak = {vel_q, {(WIDTH-VEL_WIDTH){1'b1}}};

  assign target = (sustain_level > peak) ? peak
                                         : sustain_level;

  assign atk_sum  = {1'b0, level} + {1'b0, attack_rate};
  assign dec_diff = $signed({1'b0, level})
                  - $signed({1'b0, decay_rate});
  assign rel_diff = $signed({1'b0, level})
                  - $signed({1'b0, release_rate});

  // Edges take priority over stepping; a zero rate freezes the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      level  <= '0;
      gate_q <= 1'b0;
    end else begin
      gate_q <= gate;
      if (rise) begin
        state <= ATTACK;
      end else if (fall) begin
        if (state inside {ATTACK, DECAY, SUSTAIN})
          state <= RELEASE;
      end else if (sample_tick) begin
        unique case (state)
          ATTACK: begin
            if (attack_rate != RATE_HOLD) begin
              if (atk_sum >= {1'b0, peak}) begin
                level <= peak;
                state <= DECAY;
              end else begin
                level <= atk_sum[WIDTH-1:0];
              end
            end
          end
          DECAY: begin
            if (decay_rate != RATE_HOLD) begin
              if (dec_diff <= $signed({1'b0, target})) begin
                level <= target;
                state <= SUSTAIN;
              end else begin
                level <= dec_diff[WIDTH-1:0];
              end
            end
          end
          RELEASE: begin
            if (release_rate != RATE_HOLD) begin
              if (rel_diff[WIDTH] || rel_diff == '0) begin
                level <= '0;
                state <= IDLE;
              end else begin
                level <= rel_diff[WIDTH-1:0];
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  env_scaler #(
    .WIDTH(WIDTH)
  ) u_scaler (
    .clk  (clk),
    .rst  (rst),
    .en   (sample_tick),
    .a    (sample_in),
    .b    (level),
    .p    (sample_out),
    .valid(sample_valid)
  );

  assign active    = (state != IDLE);
  assign env_state = state;

endmodule

// File: doc/envelope_adsr.md
ENVELOPE_ADSR -- requirements
Module: envelope_adsr

Interface
REQ-001 SHALL have parameter WIDTH, default 24, sample, level and rate width in bits.
REQ-002 SHALL have parameter VEL_WIDTH, default 7, velocity width (used only under ENVELOPE_VELOCITY_EN).
REQ-003 clk  input  1  system clock; one clock; all logic on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 sample_tick  input  1  one-cycle strobe at the 48 kHz sample rate; oscillator sample valid on this cycle.
REQ-006 gate  input  1  note held (1) / released (0); may change on any cycle.
REQ-007 sample_in  input  WIDTH  unsigned oscillator sample.
REQ-008 attack_rate, decay_rate, release_rate  input  WIDTH each  unsigned level step per tick.
REQ-009 sustain_level  input  WIDTH  unsigned sustain target.
REQ-010 sample_out  output  WIDTH  enveloped sample, registered.
REQ-011 sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-012 active  output  1  high whenever state is not IDLE.
REQ-013 env_state  output  env_state_t  current phase (IDLE, ATTACK, DECAY, SUSTAIN, RELEASE).

Function
REQ-014 SHALL register gate into gate_q each cycle; rise = gate & ~gate_q, fall = ~gate & gate_q.
REQ-015 rise in any state SHALL enter ATTACK next cycle without changing level (retrigger from current level).
REQ-016 fall in ATTACK, DECAY or SUSTAIN SHALL enter RELEASE next cycle; fall in IDLE/RELEASE SHALL be ignored.
REQ-017 Level SHALL change only on sample_tick cycles with no rise/fall; on coincident edge and tick the transition wins and no step occurs that tick.
REQ-018 ATTACK tick: level += attack_rate in WIDTH+1 bits; result >= PEAK SHALL clamp to PEAK and enter DECAY.
REQ-019 PEAK SHALL be 2^WIDTH-1 (without velocity feature).
REQ-020 DECAY tick: level -= decay_rate in WIDTH+1 bits signed; result <= target SHALL clamp to target and enter SUSTAIN; target = min(sustain_level, PEAK).
REQ-021 SUSTAIN: level SHALL be held; sustain_level changes SHALL NOT re-enter DECAY.
REQ-022 RELEASE tick: level -= release_rate; result <= 0 SHALL clamp to 0 and enter IDLE.
REQ-023 Rate 0 in any phase SHALL hold level and state indefinitely (no divide, no lockup beyond that).
REQ-024 On sample_tick, product = (sample_in * level) >> WIDTH using the pre-step level; sample_out SHALL be updated and sample_valid pulsed exactly 1 cycle after the tick.
REQ-025 In IDLE the product SHALL still be computed (level 0 yields sample_out 0) so sample_valid cadence is unbroken.

Reset
REQ-026 rst SHALL force state IDLE, level 0, gate_q 0, sample_out 0, sample_valid 0, active 0; latched velocity to all-ones.
REQ-027 rst mid-envelope SHALL abort immediately; gate high at reset release SHALL produce a rise on the first post-reset cycle.

Configuration
REQ-028 Macro ENVELOPE_VELOCITY_EN defined: input velocity [VEL_WIDTH-1:0] SHALL exist and be latched on rise; PEAK = {velocity, all-ones in low WIDTH-VEL_WIDTH bits}.
REQ-029 Macro undefined: no velocity port, PEAK = 2^WIDTH-1; all other behaviour identical.

Structure
REQ-030 env_state_t enum (2/3-bit) and PEAK/rate constants SHALL live in shared package env_pkg alongside the existing shape package usage.
REQ-031 Multiply-and-shift SHALL be a sub-module env_scaler (WIDTH x WIDTH unsigned, registered output, 1-cycle latency).

Verification
REQ-032 Attack: WIDTH=24, attack_rate=0x100000, gate rise from IDLE -> level 0xF00000 after 15 ticks, 0xFFFFFF and DECAY after 16th.
REQ-033 Decay/sustain: decay_rate=0x080000, sustain_level=0x800000 -> level lands exactly 0x800000, state SUSTAIN, held over 100 ticks.
REQ-034 Release: from SUSTAIN 0x800000, gate fall, release_rate=0x800000 -> RELEASE, one tick later level 0, IDLE, active 0.
REQ-035 Scaling: sample_in=0xFFFFFF, level 0xFFFFFF -> sample_out 0xFFFFFE with sample_valid 1 cycle after tick; level 0 -> 0.
REQ-036 Retrigger/coincidence: gate re-rise during RELEASE at level 0x400000 on a tick cycle -> ATTACK, level stays 0x400000 that tick.
REQ-037 Reset mid-ATTACK -> all outputs 0, IDLE next cycle; with ENVELOPE_VELOCITY_EN, velocity=64 -> attack clamps at 0x81FFFF.
